// File: rtl/quota_stream_gen_if.sv
// Handshake and data bundle for quota_stream_gen: the input vector side
// (valid/ready, words, modes) and the per-channel stream output side.
interface quota_stream_gen_if #(
  parameter int BITSTREAM = 64,
  parameter int QUANT     = 8,
  parameter int CH        = 4
);
  localparam int L = $clog2(BITSTREAM);

  logic                  in_valid;
  logic                  in_ready;
  logic [CH*QUANT-1:0]   in_data;
  logic                  mode_bipolar;
  logic                  mode_round;
  logic                  mode_spread;
  logic                  out_valid;
  logic                  out_ready;
  logic [CH-1:0]         out_bits;
  logic                  out_last;
  logic [CH*(L+1)-1:0]   out_quota;

  // Source / stream consumer side.
  modport master (
    output in_valid, in_data, mode_bipolar, mode_round, mode_spread, out_ready,
    input  in_ready, out_valid, out_bits, out_last, out_quota
  );

  // Generator side.
  modport slave (
    input  in_valid, in_data, mode_bipolar, mode_round, mode_spread, out_ready,
    output in_ready, out_valid, out_bits, out_last, out_quota
  );
endinterface

// File: rtl/quota_stream_gen.sv
// Multi-channel stochastic bitstream generator: turns CH quantised words into
// per-window quotas of ones and serialises one BITSTREAM-bit stream per channel.
module quota_stream_gen #(
  parameter int BITSTREAM = 64,
  parameter int QUANT     = 8,
  parameter int CH        = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  quota_stream_gen_if.slave     io_bus
);

  localparam int L = $clog2(BITSTREAM);
  localparam int D = QUANT - L;

  localparam logic [QUANT:0] BIAS = (QUANT+1)'(2 ** (QUANT - 1));
  localparam logic [QUANT:0] RND  = (D > 0) ? (QUANT+1)'(2 ** (D - 1)) : '0;

  generate
    if (D < 0 || BITSTREAM < 2 || BITSTREAM != (1 << L)) begin : g_bad_param
      $error("quota_stream_gen: BITSTREAM must be a power of two >= 2 and QUANT >= log2(BITSTREAM)");
    end
  endgenerate

  typedef enum logic {
    ST_IDLE,
    ST_STREAM
  } state_t;

  state_t                r_state;
  logic [L-1:0]          r_cnt;
  logic [CH-1:0][L:0]    r_quota;
  logic                  r_spread;
  logic                  r_out_valid;
  logic                  r_out_last;
  logic [CH-1:0]         r_out_bits;

  logic [CH-1:0][L:0]    w_quota;
  logic                  w_in_ready;
  logic                  w_accept;
  logic [L-1:0]          w_cnt_nxt;
  logic [L-1:0]          w_k;
  logic [CH-1:0][L:0]    w_q_sel;
  logic                  w_spread_sel;
  logic [CH-1:0]         w_bits_nxt;

  // Quota per channel: offset signed inputs into 0..2^QUANT-1, then keep the top L+1 bits.
  for (genvar c = 0; c < CH; c++) begin : g_ch
    logic [QUANT-1:0] w_x;
    logic [QUANT:0]   w_ext;
    logic [QUANT:0]   w_sum;

    assign w_x        = io_bus.in_data[c*QUANT +: QUANT];
    assign w_ext      = io_bus.mode_bipolar ? ({w_x[QUANT-1], w_x} + BIAS) : {1'b0, w_x};
    assign w_sum      = w_ext + (io_bus.mode_round ? RND : '0);
    assign w_quota[c] = (L+1)'(w_sum >> D);
  end

  // The final beat of a window reopens the input so a waiting vector follows with no bubble.
  // NOTE: every signal driven here gets a value on every path, so no latch can be inferred.
  always_comb begin
    w_in_ready   = (r_state == ST_IDLE) || (r_out_last && io_bus.out_ready);
    w_accept     = io_bus.in_valid && w_in_ready;
    w_cnt_nxt    = w_accept ? '0 : r_cnt + 1'b1;
    w_q_sel      = w_accept ? w_quota : r_quota;
    w_spread_sel = w_accept ? io_bus.mode_spread : r_spread;

    w_k = w_cnt_nxt;
    if (w_spread_sel) begin
      for (int i = 0; i < L; i++) begin
        w_k[i] = w_cnt_nxt[L-1-i];
      end
    end

    w_bits_nxt = '0;
    for (int c = 0; c < CH; c++) begin
      w_bits_nxt[c] = ({1'b0, w_k} < w_q_sel[c]);
    end
  end

  // Outputs are computed one beat ahead and registered so they hold under backpressure.
  // NOTE: all state is updated with non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the quota bank is a handful of flops, not a RAM, so it is reset with the rest.
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_quota     <= '0;
      r_spread    <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_out_bits  <= '0;
    end else if (w_accept) begin
      r_state     <= ST_STREAM;
      r_cnt       <= '0;
      r_quota     <= w_quota;
      r_spread    <= io_bus.mode_spread;
      r_out_valid <= 1'b1;
      r_out_last  <= &w_cnt_nxt;
      r_out_bits  <= w_bits_nxt;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_out_valid <= 1'b0;
          r_out_last  <= 1'b0;
          r_out_bits  <= '0;
        end
        ST_STREAM: begin
          if (io_bus.out_ready) begin
            if (r_out_last) begin
              r_state     <= ST_IDLE;
              r_cnt       <= '0;
              r_out_valid <= 1'b0;
              r_out_last  <= 1'b0;
              r_out_bits  <= '0;
            end else begin
              r_cnt      <= w_cnt_nxt;
              r_out_last <= &w_cnt_nxt;
              r_out_bits <= w_bits_nxt;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign io_bus.in_ready  = w_in_ready;
  assign io_bus.out_valid = r_out_valid;
  assign io_bus.out_bits  = r_out_bits;
  assign io_bus.out_last  = r_out_last;
  assign io_bus.out_quota = r_quota;

endmodule

// File: tb/tb_quota_stream_gen.sv
// Directed bench for quota_stream_gen: quota arithmetic, stream patterns,
// backpressure, back-to-back windows and asynchronous reset.
module tb_quota_stream_gen;

  localparam int BITSTREAM = 64;
  localparam int QUANT     = 8;
  localparam int CH        = 4;

  logic clk;
  logic rst_n;

  int n_checks = 0;
  int n_fail   = 0;

  int          ones [2][CH];
  logic [63:0] pat  [CH];
  int          n_last;
  int          err_last;
  int          err_stab;
  int          err_rdy;
  int          win_cyc;

  quota_stream_gen_if #(.BITSTREAM(BITSTREAM), .QUANT(QUANT), .CH(CH)) bus ();

  quota_stream_gen #(.BITSTREAM(BITSTREAM), .QUANT(QUANT), .CH(CH)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .io_bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // Present a vector at a falling edge and hold it through the accepting rising edge.
  task automatic send(input logic [31:0] d, input logic bp, input logic rnd, input logic spr,
                      input bit keep, input logic [31:0] nxt);
    @(negedge clk);
    bus.in_data      = d;
    bus.mode_bipolar = bp;
    bus.mode_round   = rnd;
    bus.mode_spread  = spr;
    bus.in_valid     = 1'b1;
    #1 check("in_ready_idle", bus.in_ready, 1);
    @(posedge clk);
    #1;
    if (keep) begin
      bus.in_data = nxt;
    end else begin
      bus.in_valid     = 1'b0;
      bus.mode_bipolar = ~bp;
      bus.mode_round   = ~rnd;
      bus.mode_spread  = ~spr;
      bus.in_data      = ~d;
    end
  endtask

  // Consume nbeats beats, optionally stalling 3 cycles on each of beats 5..9.
  task automatic collect(input int nbeats, input bit stall, input bit drop_at_64);
    int   b = 0;
    int   stall_left = 0;
    int   stalled_b = -1;
    logic prev_stall = 1'b0;
    logic [CH-1:0] prev_bits = '0;
    logic prev_last = 1'b0;
    n_last = 0; err_last = 0; err_stab = 0; err_rdy = 0; win_cyc = 0;
    for (int c = 0; c < CH; c++) begin
      ones[0][c] = 0;
      ones[1][c] = 0;
      pat[c]     = '0;
    end
    while (b < nbeats && win_cyc < 400) begin
      @(negedge clk);
      if (drop_at_64 && b == 64) bus.in_valid = 1'b0;
      if (stall && b >= 5 && b <= 9 && stalled_b != b) begin
        stalled_b  = b;
        stall_left = 3;
      end
      bus.out_ready = (stall_left == 0);
      if (stall_left > 0) stall_left--;
      #1;
      win_cyc++;
      if (win_cyc == 1) check("first_beat_latency", bus.out_valid, 1);
      if (prev_stall && (!bus.out_valid || bus.out_bits != prev_bits || bus.out_last != prev_last))
        err_stab++;
      if (bus.out_valid && bus.out_ready) begin
        for (int c = 0; c < CH; c++) begin
          if (bus.out_bits[c]) begin
            ones[b / 64][c]++;
            if (b < 64) pat[c][b] = 1'b1;
          end
        end
        if (bus.out_last != ((b % 64) == 63)) err_last++;
        if (bus.out_last) n_last++;
        if (bus.in_ready != ((b % 64) == 63)) err_rdy++;
        b++;
      end else if (bus.out_valid && bus.in_ready) begin
        err_rdy++;
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_bits  = bus.out_bits;
      prev_last  = bus.out_last;
    end
    if (b < nbeats) check("collect_timeout_beats", b, nbeats);
    bus.out_ready = 1'b1;
  endtask

  task automatic check_win(input string tag, input int w, input int e0, input int e1,
                           input int e2, input int e3);
    int e [CH];
    e = '{e0, e1, e2, e3};
    for (int c = 0; c < CH; c++) check($sformatf("%s_ones_ch%0d", tag, c), ones[w][c], e[c]);
  endtask

  task automatic check_common(input string tag, input int exp_last, input int exp_cyc);
    check({tag, "_last_pulses"}, n_last, exp_last);
    check({tag, "_last_position_errs"}, err_last, 0);
    check({tag, "_in_ready_errs"}, err_rdy, 0);
    check({tag, "_cycles"}, win_cyc, exp_cyc);
  endtask

  task automatic check_idle(input string tag, input logic [27:0] exp_quota);
    @(negedge clk);
    #1;
    check({tag, "_idle_valid"}, bus.out_valid, 0);
    check({tag, "_idle_bits"}, bus.out_bits, 0);
    check({tag, "_idle_ready"}, bus.in_ready, 1);
    check({tag, "_idle_quota"}, bus.out_quota, exp_quota);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n            = 1'b0;
    bus.in_valid     = 1'b0;
    bus.in_data      = '0;
    bus.mode_bipolar = 1'b0;
    bus.mode_round   = 1'b0;
    bus.mode_spread  = 1'b0;
    bus.out_ready    = 1'b1;
    #1;
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_bits", bus.out_bits, 0);
    check("rst_out_last", bus.out_last, 0);
    check("rst_out_quota", bus.out_quota, 0);
    #24 rst_n = 1'b1;

    // 1: bipolar, round: -128, 0, 127, -1 -> 0, 32, 64, 32
    send(32'hFF7F0080, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    check("t1_quota", bus.out_quota, {7'd32, 7'd64, 7'd32, 7'd0});
    collect(64, 1'b0, 1'b0);
    check_win("t1", 0, 0, 32, 64, 32);
    check_common("t1", 1, 64);
    check_idle("t1", {7'd32, 7'd64, 7'd32, 7'd0});

    // 2: unipolar truncate then round: 255, 3, 4, 128
    send(32'h800403FF, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    check("t2a_quota", bus.out_quota, {7'd32, 7'd1, 7'd0, 7'd63});
    collect(64, 1'b0, 1'b0);
    check_win("t2a", 0, 63, 0, 1, 32);
    check_common("t2a", 1, 64);
    send(32'h800403FF, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    check("t2b_quota", bus.out_quota, {7'd32, 7'd1, 7'd1, 7'd64});
    collect(64, 1'b0, 1'b0);
    check_win("t2b", 0, 64, 1, 1, 32);
    check_common("t2b", 1, 64);
    check_idle("t2b", {7'd32, 7'd1, 7'd1, 7'd64});

    // 3: quota 16 everywhere, unary then spread
    send(32'h40404040, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    collect(64, 1'b0, 1'b0);
    for (int c = 0; c < CH; c++) check($sformatf("t3_unary_pat_ch%0d", c), pat[c], 64'h0000_0000_0000_FFFF);
    send(32'h40404040, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    collect(64, 1'b0, 1'b0);
    for (int c = 0; c < CH; c++) check($sformatf("t3_spread_pat_ch%0d", c), pat[c], 64'h1111_1111_1111_1111);
    check_common("t3", 1, 64);

    // 4: backpressure on beats 5..9, 3 cycles each
    send(32'hFF7F0080, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    collect(64, 1'b1, 1'b0);
    check_win("t4", 0, 0, 32, 64, 32);
    check_common("t4", 1, 79);
    check("t4_stall_stability_errs", err_stab, 0);

    // 5: back-to-back, second vector waiting with in_valid held high
    send(32'h800403FF, 1'b0, 1'b1, 1'b0, 1'b1, 32'h40404040);
    collect(128, 1'b0, 1'b1);
    check_win("t5_w0", 0, 64, 1, 1, 32);
    check_win("t5_w1", 1, 16, 16, 16, 16);
    check_common("t5", 2, 128);
    check_idle("t5", {7'd16, 7'd16, 7'd16, 7'd16});

    // 6: asynchronous reset while on beat 20
    send(32'hFF7F0080, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    repeat (21) @(negedge clk);
    #1;
    check("t6_pre_valid", bus.out_valid, 1);
    check("t6_pre_bits_beat20", bus.out_bits, 4'b1110);
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_valid", bus.out_valid, 0);
    check("t6_rst_bits", bus.out_bits, 0);
    check("t6_rst_last", bus.out_last, 0);
    check("t6_rst_ready", bus.in_ready, 1);
    check("t6_rst_quota", bus.out_quota, 0);
    @(negedge clk);
    rst_n = 1'b1;
    send(32'h800403FF, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    collect(64, 1'b0, 1'b0);
    check_win("t6", 0, 64, 1, 1, 32);
    check_common("t6", 1, 64);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/quota_stream_gen.md
Name: quota_stream_gen

Overview:
Multi-channel stochastic-computing front end. Converts CH quantised words into quotas, i.e. the count of ones per BITSTREAM-long window, then serialises one BITSTREAM-bit stream per channel, one bit per accepted beat. Sits between the quantised activation/weight source and the stochastic multiplier array. Adds unipolar/bipolar, round/truncate and unary/spread modes, a valid/ready handshake, and back-to-back operation.

Parameters:
BITSTREAM, 64, stream length; must be 2^n; L = log2(BITSTREAM)
QUANT, 8, input word width; D = QUANT - L must be >= 0 (elaboration error otherwise)
CH, 4, number of parallel channels

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  input vector valid
in_ready  out  1  input vector accepted when in_valid && in_ready
in_data  in  CH*QUANT  channel c at bits [c*QUANT +: QUANT]
mode_bipolar  in  1  1: in_data signed two's complement; 0: unsigned
mode_round  in  1  1: round half-up; 0: truncate
mode_spread  in  1  1: evenly spread ones; 0: unary (ones first)
out_valid  out  1  stream beat valid
out_ready  in  1  beat consumed when out_valid && out_ready
out_bits  out  CH  one stream bit per channel
out_last  out  1  marks beat BITSTREAM-1
out_quota  out  CH*(L+1)  latched quota per channel, channel c at [c*(L+1) +: L+1]

Behaviour:
- One clock, clk. rst_n is asynchronous, active-low.
- Reset values: state IDLE, beat counter cnt=0, quota registers=0, mode registers=0, out_valid=0, out_last=0, out_bits=0, in_ready=1.
- Quota arithmetic, per channel, in QUANT+1 bits:
  - Bipolar: sign-extend x, then add 2^(QUANT-1).
  - Unipolar: zero-extend x.
  - If mode_round and D>0: add 2^(D-1).
  - quota = result >> D, width L+1, range 0..BITSTREAM.
- The quota is computed combinationally from in_data. It and all three mode bits are registered on the accept cycle.
- FSM IDLE:
  - in_ready=1, out_valid=0.
  - On accept: latch quotas and modes, cnt<=0, go to STREAM.
- FSM STREAM:
  - out_valid=1.
  - out_bits[c] = (k < quota_c). k = cnt in unary mode; k = bit-reverse of cnt (L bits) in spread mode.
  - Each window carries exactly quota_c ones.
  - On a beat (out_valid && out_ready), cnt increments.
  - out_last = (cnt == BITSTREAM-1).
- Final beat (out_last && out_ready):
  - cnt wraps to 0.
  - in_ready=1 combinationally in that cycle. If in_valid=1, the new vector is latched and the FSM stays in STREAM with no bubble. Otherwise it goes to IDLE.
- in_ready=0 in STREAM except on the final-beat cycle.
- Backpressure: while out_ready=0, cnt, out_bits and out_last hold stable. out_valid does not drop.
- out_bits=0 whenever out_valid=0.
- out_quota holds its value until the next accept, including while idle.
- Latency: first beat valid on the cycle after accept. One window = BITSTREAM beats minimum.
- Reset mid-stream: all outputs return immediately to reset values and the stream is discarded. The first accept is possible on the first clock edge after deassertion.
- Mode inputs are don't-care outside the accept cycle.

Test Plan:
1. Defaults; bipolar=1, round=1; in_data ch0..3 = -128, 0, 127, -1 -> out_quota = 0, 32, 64, 32. Over 64 beats the ones counts are 0, 32, 64, 32. out_last is high only on beat 63.
2. bipolar=0, round=0; in_data = 255, 3, 4, 128 -> quotas 63, 0, 1, 32. Repeat with round=1 -> 64, 1, 1, 32.
3. Quota 16 on all channels:
   - unary -> ones on beats 0..15 only.
   - spread -> ones on beats 0, 4, 8, ..., 60 (16 ones).
4. Backpressure: out_ready low on beats 5..9 for 3 cycles each -> out_bits and cnt stable while low. Still exactly 64 beats and correct ones counts. Total cycles = 64 + 15.
5. Back-to-back: in_valid held high with two vectors -> second accepted on the beat-63 cycle. Beat 0 of window 2 appears on the next cycle, so out_valid stays high for 128 consecutive cycles. out_last pulses twice.
6. rst_n asserted mid-cycle at beat 20 -> out_valid, out_bits and out_last go to 0 without waiting for clk. in_ready=1 and out_quota=0. A new vector accepted after release streams correctly from beat 0.
